// File: rtl/bit_selection_ram_rdport.sv
// Read-side bit selection for the 4x512x20 dual-port RAM block with BIST read-back check.
// Define BIT_SEL_RD_OUTREG_EN to add one more output register stage.
module bit_selection_ram_rdport #(
    parameter int         RD_LAT       = 1,
    parameter logic [2:0] CONFIG_1BIT  = 3'd1,
    parameter logic [2:0] CONFIG_2BIT  = 3'd2,
    parameter logic [2:0] CONFIG_5BIT  = 3'd3,
    parameter logic [2:0] CONFIG_10BIT = 3'd4,
    parameter logic [2:0] CONFIG_20BIT = 3'd5,
    parameter logic [2:0] CONFIG_40BIT = 3'd6,
    parameter logic [2:0] CONFIG_80BIT = 3'd7
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic [2:0]  output_config_i,
    input  logic        en_i,
    input  logic        re_i,
    input  logic [15:0] addr_i,
    input  logic [19:0] ram_data_i,
    input  logic        bist_active_i,
    input  logic [19:0] bist_expdata_i,
    input  logic [19:0] bist_bitmask_i,
    input  logic        bist_clr_i,
    output logic [19:0] data_o,
    output logic        valid_o,
    output logic        bist_fail_o,
    output logic [7:0]  bist_errcnt_o
);

    typedef struct packed {
        logic       vld;
        logic [2:0] cfg;
        logic [3:0] lane;
    } rd_tag_t;

    rd_tag_t     pipe_q [RD_LAT];
    rd_tag_t     pipe_d [RD_LAT];
    rd_tag_t     tail;
    logic [19:0] data_q, data_d;
    logic        valid_q, valid_d;
    logic        fail_q, fail_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        mismatch;

    logic unused_addr;
    assign unused_addr = ^{addr_i[15:5], addr_i[0]};

    // Lanes skip every fifth bit in x1/x2 so narrow words never straddle a 5-bit group.
    function automatic logic [19:0] sel_lane(input logic [2:0]  cfg,
                                             input logic [3:0]  lane,
                                             input logic [19:0] ram);
        logic [4:0]  idx;
        logic [19:0] shf;
        logic [19:0] res;
        idx = '0;
        res = '0;
        case (cfg)
            CONFIG_1BIT:  idx = {1'b0, lane} + {3'b0, lane[3:2]};
            CONFIG_2BIT:  idx = {1'b0, lane[3:1], 1'b0} + {3'b0, lane[3:2]};
            CONFIG_5BIT:  idx = {1'b0, lane[3:2], 2'b00} + {3'b0, lane[3:2]};
            default:      idx = '0;
        endcase
        shf = ram >> idx;
        case (cfg)
            CONFIG_1BIT:  res = {19'b0, shf[0]};
            CONFIG_2BIT:  res = {18'b0, shf[1:0]};
            CONFIG_5BIT:  res = {15'b0, shf[4:0]};
            CONFIG_10BIT: res = {10'b0, lane[3] ? ram[19:10] : ram[9:0]};
            CONFIG_20BIT,
            CONFIG_40BIT,
            CONFIG_80BIT: res = ram;
            default:      res = '0;
        endcase
        return res;
    endfunction

    always_comb begin
        pipe_d[0].vld  = en_i & re_i;
        pipe_d[0].cfg  = output_config_i;
        pipe_d[0].lane = addr_i[4:1];
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
    end

    assign tail = pipe_q[RD_LAT-1];

    always_comb begin
        data_d   = data_q;
        valid_d  = tail.vld;
        fail_d   = fail_q;
        cnt_d    = cnt_q;
        mismatch = tail.vld & bist_active_i &
                   (|((ram_data_i ^ bist_expdata_i) & bist_bitmask_i));
        if (tail.vld) begin
            data_d = bist_active_i ? ram_data_i
                                   : sel_lane(tail.cfg, tail.lane, ram_data_i);
        end
        if (bist_clr_i) begin
            fail_d = 1'b0;
            cnt_d  = '0;
        end else if (mismatch) begin
            fail_d = 1'b1;
            if (cnt_q != 8'hFF) begin
                cnt_d = cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= '0;
            end
            data_q  <= '0;
            valid_q <= 1'b0;
            fail_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            data_q  <= data_d;
            valid_q <= valid_d;
            fail_q  <= fail_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef BIT_SEL_RD_OUTREG_EN
    logic [19:0] odata_q, odata_d;
    logic        ovalid_q, ovalid_d;
    logic        ofail_q, ofail_d;
    logic [7:0]  ocnt_q, ocnt_d;

    always_comb begin
        odata_d  = data_q;
        ovalid_d = valid_q;
        ofail_d  = fail_q;
        ocnt_d   = cnt_q;
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            odata_q  <= '0;
            ovalid_q <= 1'b0;
            ofail_q  <= 1'b0;
            ocnt_q   <= '0;
        end else begin
            odata_q  <= odata_d;
            ovalid_q <= ovalid_d;
            ofail_q  <= ofail_d;
            ocnt_q   <= ocnt_d;
        end
    end

    assign data_o        = odata_q;
    assign valid_o       = ovalid_q;
    assign bist_fail_o   = ofail_q;
    assign bist_errcnt_o = ocnt_q;
`else
    assign data_o        = data_q;
    assign valid_o       = valid_q;
    assign bist_fail_o   = fail_q;
    assign bist_errcnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_bit_selection_ram_rdport.sv
// Bench for bit_selection_ram_rdport: cycle-indexed input history plus a lane-table model.
// Define BIT_SEL_RD_OUTREG_EN to check the extra output stage.
module tb_bit_selection_ram_rdport;

    localparam int RD_LAT = 1;
`ifdef BIT_SEL_RD_OUTREG_EN
    localparam int XL = 1;
`else
    localparam int XL = 0;
`endif

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [2:0]  cfg = '0;
    logic        en = 1'b0;
    logic        re = 1'b0;
    logic [15:0] addr = '0;
    logic [19:0] ram = '0;
    logic        bact = 1'b0;
    logic [19:0] bexp = '0;
    logic [19:0] bmask = '0;
    logic        bclr = 1'b0;
    logic [19:0] data_o;
    logic        valid_o;
    logic        fail_o;
    logic [7:0]  cnt_o;

    always #5 clk = ~clk;

    bit_selection_ram_rdport #(.RD_LAT(RD_LAT)) dut (
        .clk_i(clk), .rstn_i(rstn), .output_config_i(cfg),
        .en_i(en), .re_i(re), .addr_i(addr), .ram_data_i(ram),
        .bist_active_i(bact), .bist_expdata_i(bexp),
        .bist_bitmask_i(bmask), .bist_clr_i(bclr),
        .data_o(data_o), .valid_o(valid_o),
        .bist_fail_o(fail_o), .bist_errcnt_o(cnt_o)
    );

    int checks = 0;
    int failures = 0;
    int cyc_n = 0;
    bit chk_on = 1'b0;

    bit          h_launch [256];
    logic [2:0]  h_cfg    [256];
    logic [15:0] h_addr   [256];
    logic [19:0] h_ram    [256];
    bit          h_bact   [256];
    logic [19:0] h_exp    [256];
    logic [19:0] h_mask   [256];
    bit          h_clr    [256];

    logic [19:0] m_data = '0;
    bit          m_valid = 1'b0;
    bit          m_fail = 1'b0;
    int          m_cnt = 0;

    int x1_map [16] = '{0, 1, 2, 3, 5, 6, 7, 8, 10, 11, 12, 13, 15, 16, 17, 18};
    int x2_map [8]  = '{0, 2, 5, 7, 10, 12, 15, 17};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc_n);
        end
    endtask

    function automatic logic [19:0] model_sel(input logic [2:0] c,
                                              input logic [15:0] a,
                                              input logic [19:0] r);
        logic [19:0] v;
        int b;
        v = '0;
        case (c)
            3'd1: v[0] = r[x1_map[a[4:1]]];
            3'd2: begin
                b = x2_map[a[4:2]];
                v[0] = r[b];
                v[1] = r[b+1];
            end
            3'd3: v = (r >> (5 * int'(a[4:3]))) & 20'h1F;
            3'd4: v = a[4] ? {10'b0, r[19:10]} : {10'b0, r[9:0]};
            3'd5, 3'd6, 3'd7: v = r;
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic step(input bit e, input bit rr, input logic [2:0] c,
                        input logic [15:0] a, input logic [19:0] rd,
                        input bit ba, input logic [19:0] ex,
                        input logic [19:0] mk, input bit cl);
        int i;
        @(posedge clk);
        cyc_n++;
        #1;
        en = e; re = rr; cfg = c; addr = a; ram = rd;
        bact = ba; bexp = ex; bmask = mk; bclr = cl;
        i = cyc_n & 255;
        h_launch[i] = e & rr;
        h_cfg[i] = c; h_addr[i] = a; h_ram[i] = rd;
        h_bact[i] = ba; h_exp[i] = ex; h_mask[i] = mk; h_clr[i] = cl;
    endtask

    task automatic idle();
        step(0, 0, 3'd0, 16'h0, 20'h0, 0, 20'h0, 20'h0, 0);
    endtask

    // One read: launch, return data over RD_LAT cycles, then wait until it is visible.
    task automatic rd1(input logic [2:0] c, input logic [15:0] a,
                       input logic [19:0] rd, input bit ba,
                       input logic [19:0] ex, input logic [19:0] mk, input bit cl);
        step(1, 1, c, a, 20'h0, 0, 20'h0, 20'h0, 0);
        repeat (RD_LAT) step(0, 0, 3'd0, 16'h0, rd, ba, ex, mk, cl);
        repeat (XL + 1) idle();
    endtask

    task automatic clear_model();
        for (int i = 0; i < 256; i++) begin
            h_launch[i] = 0; h_bact[i] = 0; h_clr[i] = 0;
            h_cfg[i] = '0; h_addr[i] = '0; h_ram[i] = '0;
            h_exp[i] = '0; h_mask[i] = '0;
        end
        m_data = '0; m_valid = 0; m_fail = 0; m_cnt = 0;
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            int r;
            int ri;
            int li;
            bit ret;
            r  = cyc_n - 1 - XL;
            ri = r & 255;
            li = (r - RD_LAT) & 255;
            ret = h_launch[li];
            m_valid = ret;
            if (ret) begin
                m_data = h_bact[ri] ? h_ram[ri]
                                    : model_sel(h_cfg[li], h_addr[li], h_ram[ri]);
            end
            if (h_clr[ri]) begin
                m_fail = 0;
                m_cnt = 0;
            end else if (ret && h_bact[ri] &&
                         ((h_ram[ri] ^ h_exp[ri]) & h_mask[ri]) != 20'h0) begin
                m_fail = 1;
                if (m_cnt < 255) m_cnt++;
            end
            chk("m_valid", {31'b0, valid_o}, {31'b0, m_valid});
            chk("m_data", {12'b0, data_o}, {12'b0, m_data});
            chk("m_fail", {31'b0, fail_o}, {31'b0, m_fail});
            chk("m_cnt", {24'b0, cnt_o}, m_cnt[31:0]);
        end
    end

    initial begin
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("rst_data", {12'b0, data_o}, 32'h0);
        chk("rst_valid", {31'b0, valid_o}, 32'h0);
        chk("rst_fail", {31'b0, fail_o}, 32'h0);
        chk("rst_cnt", {24'b0, cnt_o}, 32'h0);
        chk_on = 1'b1;
        idle();

        // T1: x1 lane 13 maps to bit 16
        step(1, 1, 3'd1, 16'd13 << 1, 20'h0, 0, 20'h0, 20'h0, 0);
        repeat (RD_LAT) step(0, 0, 3'd0, 16'h0, 20'h10000, 0, 20'h0, 20'h0, 0);
        repeat (XL) idle();
        chk("t1_early", {31'b0, valid_o}, 32'h0);
        idle();
        chk("t1_data", {12'b0, data_o}, 32'h00001);
        chk("t1_valid", {31'b0, valid_o}, 32'h1);
        idle();
        chk("t1_strobe", {31'b0, valid_o}, 32'h0);
        chk("t1_hold", {12'b0, data_o}, 32'h00001);

        // T2: x5 and x10
        rd1(3'd3, 16'd2 << 3, 20'h07C00, 0, 20'h0, 20'h0, 0);
        chk("t2_x5", {12'b0, data_o}, 32'h0001F);
        rd1(3'd4, 16'h0010, 20'hABC00, 0, 20'h0, 20'h0, 0);
        chk("t2_x10", {12'b0, data_o}, 32'h002AF);
        rd1(3'd2, 16'd3 << 2, 20'h00180, 0, 20'h0, 20'h0, 0);
        chk("t2_x2", {12'b0, data_o}, 32'h00003);
        rd1(3'd0, 16'hFFFF, 20'hFFFFF, 0, 20'h0, 20'h0, 0);
        chk("t2_badcfg", {12'b0, data_o}, 32'h0);

        // T3: back-to-back reads with a config switch in flight
        for (int i = 0; i < 40; i++) begin
            step(1, 1, (i < 20) ? 3'd2 : 3'd5, 16'($urandom),
                 20'($urandom), 0, 20'h0, 20'h0, 0);
            if (i >= RD_LAT + 1 + XL) chk("t3_nobubble", {31'b0, valid_o}, 32'h1);
        end
        repeat (RD_LAT + XL + 2) idle();

        // T4: BIST compare, mask, clear, saturation
        rd1(3'd1, 16'h0, 20'hFFFFE, 1, 20'hFFFFF, 20'hFFFFE, 0);
        chk("t4_masked_fail", {31'b0, fail_o}, 32'h0);
        chk("t4_bypass", {12'b0, data_o}, 32'hFFFFE);
        rd1(3'd1, 16'h0, 20'hFFFFE, 1, 20'hFFFFF, 20'hFFFFF, 0);
        chk("t4_fail", {31'b0, fail_o}, 32'h1);
        chk("t4_cnt1", {24'b0, cnt_o}, 32'h1);
        rd1(3'd1, 16'h0, 20'hFFFFE, 1, 20'hFFFFF, 20'hFFFFF, 1);
        chk("t5_clr_fail", {31'b0, fail_o}, 32'h0);
        chk("t5_clr_cnt", {24'b0, cnt_o}, 32'h0);
        for (int i = 0; i < 300 + RD_LAT; i++) begin
            step(i < 300, 1, 3'd5, 16'h0, 20'hFFFFE, 1, 20'hFFFFF, 20'hFFFFF, 0);
        end
        repeat (XL + 1) idle();
        chk("t4_sat", {24'b0, cnt_o}, 32'hFF);

        // T5: reset while a read is in flight
        step(1, 1, 3'd5, 16'h0, 20'h0, 0, 20'h0, 20'h0, 0);
        step(0, 0, 3'd0, 16'h0, 20'hABCDE, 0, 20'h0, 20'h0, 0);
        chk_on = 1'b0;
        rstn = 1'b0;
        idle();
        rstn = 1'b1;
        clear_model();
        chk_on = 1'b1;
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("t5_valid", {31'b0, valid_o}, 32'h0);
        end
        chk("t5_data", {12'b0, data_o}, 32'h0);
        chk("t5_fail", {31'b0, fail_o}, 32'h0);
        chk("t5_cnt", {24'b0, cnt_o}, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic [19:0] rv;
            rv = 20'($urandom);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 3'($urandom_range(0, 7)), 16'($urandom), rv,
                 $urandom_range(0, 3) == 0,
                 rv ^ (($urandom_range(0, 1) == 0) ? 20'h0 : 20'($urandom)),
                 20'($urandom), $urandom_range(0, 19) == 0);
        end
        repeat (RD_LAT + XL + 2) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
